// File: rtl/muldiv_sched.sv
// Sequencer for the multi-cycle multiplier/divider: launches one HI/LO operation,
// waits for the unit's done flag, commits HI/LO and reports divide-by-zero/timeout.
module muldiv_sched #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rd_data,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_start,
    input  logic        div_done,
    input  logic        div_zero,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        div_zero_exc,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DIV, S_WAIT_MULT, S_DONE, S_EXC
    } state_t;

    localparam logic [1:0]       OP_MULT   = 2'b00;
    localparam logic [1:0]       OP_DIV    = 2'b01;
    localparam logic [1:0]       OP_MFHI   = 2'b10;
    localparam logic [1:0]       OP_MFLO   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ARM   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              div_start_q, div_start_d;
    logic              mult_start_q, mult_start_d;
    logic              div_zero_exc_q, div_zero_exc_d;
    logic              timeout_q, timeout_d;

    logic              in_div;
    logic              armed;
    logic              unit_done;
    logic              unit_zero;
    logic [31:0]       unit_hi;
    logic [31:0]       unit_lo;

    // The done flags of the previous operation may still be high, so they are masked until cnt reaches 2.
    assign in_div    = (state_q == S_WAIT_DIV);
    assign armed     = (cnt_q >= CNT_ARM);
    assign unit_done = armed && (in_div ? div_done : mult_done);
    assign unit_zero = armed && in_div && div_zero;
    assign unit_hi   = in_div ? div_hi : mult_hi;
    assign unit_lo   = in_div ? div_lo : mult_lo;

    always_comb begin
        // NOTE: every *_d gets a default before the case so no path leaves one unassigned (no latches).
        state_d        = state_q;
        cnt_d          = cnt_q;
        busy_d         = busy_q;
        rd_data_d      = rd_data_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        div_start_d    = div_start_q;
        mult_start_d   = mult_start_q;
        ack_d          = 1'b0;
        div_zero_exc_d = 1'b0;
        timeout_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d       = 1'b0;
                div_start_d  = 1'b0;
                mult_start_d = 1'b0;
                if (req) begin
                    unique case (op)
                        OP_MFHI: begin
                            rd_data_d = hi_q;
                            ack_d     = 1'b1;
                        end
                        OP_MFLO: begin
                            rd_data_d = lo_q;
                            ack_d     = 1'b1;
                        end
                        OP_DIV: begin
                            state_d     = S_WAIT_DIV;
                            div_start_d = 1'b1;
                            busy_d      = 1'b1;
                            cnt_d       = '0;
                        end
                        OP_MULT: begin
                            state_d      = S_WAIT_MULT;
                            mult_start_d = 1'b1;
                            busy_d       = 1'b1;
                            cnt_d        = '0;
                        end
                        default: ;
                    endcase
                end
            end

            S_WAIT_DIV, S_WAIT_MULT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // Priority: divide-by-zero, then done, then timeout.
                if (unit_zero) begin
                    state_d        = S_EXC;
                    div_zero_exc_d = 1'b1;
                end else if (unit_done) begin
                    state_d = S_DONE;
                    hi_d    = unit_hi;
                    lo_d    = unit_lo;
                end else if (cnt_q >= CNT_LIMIT) begin
                    state_d   = S_EXC;
                    timeout_d = 1'b1;
                end
                if (state_d != state_q) begin
                    ack_d        = 1'b1;
                    busy_d       = 1'b0;
                    div_start_d  = 1'b0;
                    mult_start_d = 1'b0;
                end
            end

            S_DONE, S_EXC: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            ack_q          <= 1'b0;
            rd_data_q      <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            div_start_q    <= 1'b0;
            mult_start_q   <= 1'b0;
            div_zero_exc_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            ack_q          <= ack_d;
            rd_data_q      <= rd_data_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            div_start_q    <= div_start_d;
            mult_start_q   <= mult_start_d;
            div_zero_exc_q <= div_zero_exc_d;
            timeout_q      <= timeout_d;
        end
    end

    assign busy         = busy_q;
    assign ack          = ack_q;
    assign rd_data      = rd_data_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;
    assign div_start    = div_start_q;
    assign mult_start   = mult_start_q;
    assign div_zero_exc = div_zero_exc_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed scenarios plus randomized operations
// checked against a per-transaction model of latency, outcome and HI/LO contents.
module tb_muldiv_sched;

    localparam int         TIMEOUT = 40;
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MFHI = 2'b10;
    localparam logic [1:0] OP_MFLO = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        busy, ack, div_start, mult_start, div_zero_exc, timeout;
    logic [31:0] rd_data, hi_out, lo_out;
    logic        div_done = 1'b0, div_zero = 1'b0, mult_done = 1'b0;
    logic [31:0] div_hi = '0, div_lo = '0, mult_hi = '0, mult_lo = '0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_sched #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op),
        .busy(busy), .ack(ack), .rd_data(rd_data), .hi_out(hi_out), .lo_out(lo_out),
        .div_start(div_start), .div_done(div_done), .div_zero(div_zero),
        .div_hi(div_hi), .div_lo(div_lo),
        .mult_start(mult_start), .mult_done(mult_done),
        .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_zero_exc(div_zero_exc), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Issues one operation starting at a negedge and ends at a negedge. For DIV/MULT the
    // unit raises its flag (div_zero or done) at cycle done_at after the start edge and
    // holds it; stale=1 also holds the done flags high in cycles 0 and 1.
    task automatic run_op(input logic [1:0] o, input int done_at, input bit zero,
                          input bit both, input bit stale, input logic [31:0] rh,
                          input logic [31:0] rl, input bit hold_req, input string name);
        logic [31:0] exp_rd;
        bit          is_div, flag, st, exp_to, exp_zx;
        int          k_end, got, busy_cnt;
        req = 1'b1;
        op  = o;
        @(posedge clk);
        @(negedge clk);
        if (!hold_req) req = 1'b0;
        if (o[1]) begin
            exp_rd = o[0] ? m_lo : m_hi;
            checks++;
            if ({ack, busy, div_start, mult_start} !== 4'b1000 || rd_data !== exp_rd)
                begin errors++; $display("FAIL %s mf_ack: ack/busy/ds/ms=%b rd=%h want 1000 rd=%h",
                    name, {ack, busy, div_start, mult_start}, rd_data, exp_rd); end
            req = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ack !== 1'b0 || rd_data !== exp_rd)
                begin errors++; $display("FAIL %s mf_hold: ack=%b rd=%h want ack=0 rd=%h",
                    name, ack, rd_data, exp_rd); end
            return;
        end
        is_div = (o == OP_DIV);
        checks++;
        if ({busy, ack, div_start, mult_start} !== {2'b10, is_div, !is_div})
            begin errors++; $display("FAIL %s launch: busy/ack/ds/ms=%b want %b", name,
                {busy, ack, div_start, mult_start}, {2'b10, is_div, !is_div}); end

        k_end  = (done_at < 2) ? 2 : done_at;
        exp_to = (k_end > TIMEOUT);
        if (exp_to) k_end = TIMEOUT;
        exp_zx = zero && is_div && !exp_to;

        got      = -1;
        busy_cnt = 0;
        for (int k = 0; k < TIMEOUT + 20; k++) begin
            flag = (k >= done_at);
            st   = stale && (k < 2);
            if (is_div) begin
                div_done  = (zero ? (both && flag) : flag) || st;
                div_zero  = zero && flag;
                mult_done = st;
                div_hi = rh;  div_lo = rl;  mult_hi = ~rh; mult_lo = ~rl;
            end else begin
                div_done  = st;
                div_zero  = 1'b0;
                mult_done = flag || st;
                mult_hi = rh; mult_lo = rl; div_hi = ~rh;  div_lo = ~rl;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
            @(negedge clk);
            if (ack) begin got = k; break; end
        end
        req = 1'b0;
        if (!exp_to && !exp_zx) begin m_hi = rh; m_lo = rl; end

        checks++;
        if (got != k_end)
            begin errors++; $display("FAIL %s ack_cycle: got=%0d want %0d", name, got, k_end); end
        checks++;
        if (busy_cnt != k_end + 1)
            begin errors++; $display("FAIL %s busy_len: got=%0d want %0d", name, busy_cnt, k_end + 1); end
        checks++;
        if ({busy, div_start, mult_start, div_zero_exc, timeout} !== {3'b000, exp_zx, exp_to})
            begin errors++; $display("FAIL %s end_flags: busy/ds/ms/zx/to=%b want %b", name,
                {busy, div_start, mult_start, div_zero_exc, timeout}, {3'b000, exp_zx, exp_to}); end
        checks++;
        if (hi_out !== m_hi || lo_out !== m_lo)
            begin errors++; $display("FAIL %s hilo: hi=%h lo=%h want hi=%h lo=%h", name,
                hi_out, lo_out, m_hi, m_lo); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack, busy, div_start, mult_start, div_zero_exc, timeout} !== 6'b0)
            begin errors++; $display("FAIL %s after_ack: ack/busy/ds/ms/zx/to=%b want 000000", name,
                {ack, busy, div_start, mult_start, div_zero_exc, timeout}); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, ack, div_start, mult_start, div_zero_exc, timeout} !== 6'b0 ||
            rd_data !== '0 || hi_out !== '0 || lo_out !== '0)
            begin errors++; $display("FAIL reset_state: flags=%b rd=%h hi=%h lo=%h want all 0",
                {busy, ack, div_start, mult_start, div_zero_exc, timeout}, rd_data, hi_out, lo_out); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_div_basic();
        run_op(OP_DIV, 35, 1'b0, 1'b0, 1'b0, 32'd2, 32'd14, 1'b0, "div_100_7");
        run_op(OP_MFHI, 0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "mfhi_after_div");
        run_op(OP_MFLO, 0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "mflo_after_div");
    endtask

    task automatic test_div_zero();
        run_op(OP_DIV, 2, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, "div_zero");
    endtask

    task automatic test_mult_stale();
        run_op(OP_MULT, 5, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_0000, 1'b0, "mult_stale");
    endtask

    task automatic test_timeout();
        run_op(OP_MULT, 1000, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "mult_timeout");
        run_op(OP_MFLO, 0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "mflo_after_timeout");
        run_op(OP_MULT, 40, 1'b0, 1'b0, 1'b0, 32'h0BAD_CAFE, 32'h0000_0040, 1'b0, "done_beats_timeout");
    endtask

    task automatic test_ignore_req();
        run_op(OP_DIV, 10, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0021, 1'b1, "req_held");
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, busy, div_start, mult_start} !== 4'b0)
            begin errors++; $display("FAIL req_held_quiet: ack/busy/ds/ms=%b want 0000",
                {ack, busy, div_start, mult_start}); end
    endtask

    task automatic test_reset_mid_op();
        req = 1'b1;
        op  = OP_DIV;
        div_done = 1'b0; div_zero = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        checks++;
        if ({busy, ack, div_start, mult_start, div_zero_exc, timeout} !== 6'b0 ||
            rd_data !== '0 || hi_out !== '0 || lo_out !== '0)
            begin errors++; $display("FAIL reset_mid_op: flags=%b rd=%h hi=%h lo=%h want all 0",
                {busy, ack, div_start, mult_start, div_zero_exc, timeout}, rd_data, hi_out, lo_out); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(OP_MFLO, 0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "mflo_after_reset");
    endtask

    task automatic test_random();
        logic [1:0] o;
        int         d;
        bit         z;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            d = int'($urandom_range(0, 46));
            z = (o == OP_DIV) && ($urandom_range(0, 4) == 0);
            run_op(o, d, z, 1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom),
                   $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_div_zero();
        test_mult_stale();
        test_timeout();
        test_ignore_req();
        test_random();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
